// File: rtl/vga_pkg.sv
// vga_pkg: shared types and default timing for the 640x480@60 Hz raster.
//   coord_t                     - 10-bit pixel/line coordinate
//   H_*_DEF / V_*_DEF           - default porch/sync/visible widths
//   axis_total/h_total/v_total  - derive the per-axis period from its four segments
package vga_pkg;

   typedef logic [9:0] coord_t;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int COORD_LIMIT   = 1024;

   function automatic int axis_total(input int visible, input int front,
                                     input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   function automatic int h_total(input int visible, input int front,
                                  input int sync, input int back);
      return axis_total(visible, front, sync, back);
   endfunction

   function automatic int v_total(input int visible, input int front,
                                  input int sync, input int back);
      return axis_total(visible, front, sync, back);
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical).
//   vga_clk, reset_n (sync, active low), en (count enable)
//   count        - registered position (reset 0)
//   count_next   - position after this edge
//   wrap         - combinational, high at TOTAL-1 while enabled
//   visible_next - count_next lies in the visible segment
//   sync_n_next  - active-low sync decode of count_next
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int VISIBLE = H_VISIBLE_DEF,
   parameter int FRONT   = H_FRONT_DEF,
   parameter int SYNC    = H_SYNC_DEF,
   parameter int BACK    = H_BACK_DEF
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   input  logic       en,
   output logic [9:0] count,
   output logic [9:0] count_next,
   output logic       wrap,
   output logic       visible_next,
   output logic       sync_n_next
);

   localparam int     TOTAL    = axis_total(VISIBLE, FRONT, SYNC, BACK);
   localparam coord_t LAST     = coord_t'(TOTAL - 1);
   localparam coord_t VIS_END  = coord_t'(VISIBLE);
   localparam coord_t SYNC_BEG = coord_t'(VISIBLE + FRONT);
   localparam coord_t SYNC_END = coord_t'(VISIBLE + FRONT + SYNC);

   coord_t count_q;
   coord_t count_d;
   logic   wrap_s;

   // next-count: wrap to zero at the end of the axis, otherwise step when enabled
   always_comb begin
      wrap_s = en && (count_q == LAST);
      if (wrap_s) begin
         count_d = 10'd0;
      end else if (en) begin
         count_d = count_q + 10'd1;
      end else begin
         count_d = count_q;
      end
   end

   // position register
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         count_q <= 10'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count        = count_q;
   assign count_next   = count_d;
   assign wrap         = wrap_s;
   // decodes look at the next value so they register in step with count_q
   assign visible_next = (count_d < VIS_END);
   assign sync_n_next  = !((count_d >= SYNC_BEG) && (count_d < SYNC_END));

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz raster timing on the 25 MHz pixel clock.
//   vga_clk     - pixel clock, all logic on posedge
//   reset_n     - synchronous active-low reset
//   DrawX/DrawY - current pixel coordinate
//   blank       - 1 while the pixel is visible
//   hs/vs       - active-low sync pulses
//   line_start  - pulse at DrawX==0; frame_start - pulse at (0,0)
// Build option: VGA_SYNC_ALIGN_EN delays hs/vs by one clock to line them up
// with renderers that register RGB one clock after DrawX/DrawY.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start
);

   localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
   end

   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       h_wrap;
   logic       v_wrap;
   logic       h_vis;
   logic       v_vis;
   logic       h_sync_n;
   logic       v_sync_n;

   logic blank_d, blank_q;
   logic hs_d, hs_q;
   logic vs_d, vs_q;
   logic line_start_d, line_start_q;
   logic frame_start_d, frame_start_q;

   // the counter registers double as the DrawX/DrawY output registers
   vga_axis_counter #(
      .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
   ) u_h (
      .vga_clk(vga_clk), .reset_n(reset_n), .en(1'b1),
      .count(DrawX), .count_next(h_next), .wrap(h_wrap),
      .visible_next(h_vis), .sync_n_next(h_sync_n)
   );

   vga_axis_counter #(
      .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
   ) u_v (
      .vga_clk(vga_clk), .reset_n(reset_n), .en(h_wrap),
      .count(DrawY), .count_next(v_next), .wrap(v_wrap),
      .visible_next(v_vis), .sync_n_next(v_sync_n)
   );

   // output decodes of the next pixel; vs is whole-line since v_next only moves on h wrap
   always_comb begin
      blank_d       = h_vis && v_vis;
      hs_d          = h_sync_n;
      vs_d          = v_sync_n;
      line_start_d  = (h_next == 10'd0);
      frame_start_d = (h_next == 10'd0) && (v_next == 10'd0);
   end

   // output registers
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         blank_q       <= 1'b0;
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         blank_q       <= blank_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign blank       = blank_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_SYNC_ALIGN_EN
   logic hs_dly_d, hs_dly_q;
   logic vs_dly_d, vs_dly_q;

   // one extra stage on the syncs only
   always_comb begin
      hs_dly_d = hs_q;
      vs_dly_d = vs_q;
   end

   // sync delay registers, idle high
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         hs_dly_q <= 1'b1;
         vs_dly_q <= 1'b1;
      end else begin
         hs_dly_q <= hs_dly_d;
         vs_dly_q <= vs_dly_d;
      end
   end

   assign hs = hs_dly_q;
   assign vs = vs_dly_q;
`else
   assign hs = hs_q;
   assign vs = vs_q;
`endif

   // v wrap coincides with frame_start_d; nothing else needs it
   logic unused_v_wrap;
   assign unused_v_wrap = v_wrap;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: dut_d uses the default 640x480 timing for reset and
// single-line checks; dut_s uses a shrunken raster (32x17) so whole
// frames, the frame wrap and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_ALIGN_EN
   localparam int SD = 1;
`else
   localparam int SD = 0;
`endif

   logic       vga_clk = 1'b0;
   logic       rst_d_n;
   logic       rst_s_n;
   logic [9:0] dx_d, dy_d, dx_s, dy_s;
   logic       blank_d, hs_d, vs_d, ls_d, fs_d;
   logic       blank_s, hs_s, vs_s, ls_s, fs_s;

   int checks = 0;
   int errors = 0;

   always #20 vga_clk = ~vga_clk;

   vga_timing_gen dut_d (
      .vga_clk(vga_clk), .reset_n(rst_d_n),
      .DrawX(dx_d), .DrawY(dy_d), .blank(blank_d), .hs(hs_d), .vs(vs_d),
      .line_start(ls_d), .frame_start(fs_d)
   );

   vga_timing_gen #(
      .H_VISIBLE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(2),
      .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) dut_s (
      .vga_clk(vga_clk), .reset_n(rst_s_n),
      .DrawX(dx_s), .DrawY(dy_s), .blank(blank_s), .hs(hs_s), .vs(vs_s),
      .line_start(ls_s), .frame_start(fs_s)
   );

   task automatic tick();
      @(posedge vga_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int blank_fall, hs_fall, hs_rise, hs_low, period;
      int vs_low, vs_bad, vs_fall_x, vs_fall_y, blank_bad, ls_cnt, fs_cnt, fs_gap, last_fs;
      logic prev_vs;

      rst_d_n = 1'b0;
      rst_s_n = 1'b0;
      repeat (5) tick();

      // reset values
      check("rst_drawx", 32'(dx_d), 32'd0);
      check("rst_drawy", 32'(dy_d), 32'd0);
      check("rst_blank", 32'(blank_d), 32'd0);
      check("rst_hs", 32'(hs_d), 32'd1);
      check("rst_vs", 32'(vs_d), 32'd1);
      check("rst_line_start", 32'(ls_d), 32'd0);
      check("rst_frame_start", 32'(fs_d), 32'd0);
      check("rst_s_drawx", 32'(dx_s), 32'd0);
      check("rst_s_vs", 32'(vs_s), 32'd1);

      // first released edge describes pixel (1,0)
      rst_d_n = 1'b1;
      rst_s_n = 1'b1;
      tick();
      check("rel_drawx", 32'(dx_d), 32'd1);
      check("rel_drawy", 32'(dy_d), 32'd0);
      check("rel_blank", 32'(blank_d), 32'd1);
      check("rel_line_start", 32'(ls_d), 32'd0);
      check("rel_frame_start", 32'(fs_d), 32'd0);
      check("rel_hs", 32'(hs_d), 32'd1);
      check("rel_s_drawx", 32'(dx_s), 32'd1);

      // default timing: walk to the start of line 1
      n = 0;
      while (ls_d !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check("line1_wait_clocks", n, 799);
      check("line1_drawx", 32'(dx_d), 32'd0);
      check("line1_drawy", 32'(dy_d), 32'd1);
      check("line1_blank", 32'(blank_d), 32'd1);

      blank_fall = -1; hs_fall = -1; hs_rise = -1; hs_low = 0; period = -1;
      for (int c = 1; c <= 800; c++) begin
         tick();
         if (blank_fall < 0 && blank_d === 1'b0) blank_fall = int'(dx_d);
         if (hs_d === 1'b0) hs_low++;
         if (hs_fall < 0 && hs_d === 1'b0) hs_fall = int'(dx_d);
         if (hs_fall >= 0 && hs_rise < 0 && hs_d === 1'b1) hs_rise = int'(dx_d);
         if (period < 0 && ls_d === 1'b1) period = c;
      end
      check("blank_fall_x", blank_fall, 640);
      check("hs_fall_x", hs_fall, 656 + SD);
      check("hs_rise_x", hs_rise, 752 + SD);
      check("hs_low_clocks", hs_low, 96);
      check("line_period", period, 800);
      check("line2_drawy", 32'(dy_d), 32'd2);
      check("line2_vs", 32'(vs_d), 32'd1);

      // small raster: align to a frame start, then run two frames
      n = 0;
      while (fs_s !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      check("s_frame_found", 32'(n < 2000), 32'd1);
      check("s_frame_at_origin", 32'({dx_s, dy_s}), 32'd0);

      vs_low = 0; vs_bad = 0; vs_fall_x = -1; vs_fall_y = -1;
      blank_bad = 0; ls_cnt = 0; fs_cnt = 0; fs_gap = -1; last_fs = 0;
      prev_vs = vs_s;
      for (int c = 1; c <= 1088; c++) begin
         tick();
         if (vs_s === 1'b0) vs_low++;
         if (vs_s !== prev_vs && dx_s !== 10'(SD)) vs_bad++;
         if (prev_vs === 1'b1 && vs_s === 1'b0 && vs_fall_y < 0) begin
            vs_fall_y = int'(dy_s);
            vs_fall_x = int'(dx_s);
         end
         prev_vs = vs_s;
         if (dy_s >= 10'd10 && blank_s !== 1'b0) blank_bad++;
         if (dy_s < 10'd10 && dx_s < 10'd20 && blank_s !== 1'b1) blank_bad++;
         if (ls_s === 1'b1) ls_cnt++;
         if (fs_s === 1'b1) begin
            fs_cnt++;
            if (fs_gap < 0) fs_gap = c - last_fs;
            last_fs = c;
         end
      end
      check("s_vs_low_clocks", vs_low, 128);
      check("s_vs_change_off_line_start", vs_bad, 0);
      check("s_vs_fall_line", vs_fall_y, 12);
      check("s_vs_fall_x", vs_fall_x, SD);
      check("s_blank_pattern", blank_bad, 0);
      check("s_line_starts", ls_cnt, 34);
      check("s_frame_starts", fs_cnt, 2);
      check("s_frame_gap", fs_gap, 544);
      check("s_last_frame_start", last_fs, 1088);

      // frame wrap (31,16) -> (0,0)
      n = 0;
      while (!(dx_s == 10'd31 && dy_s == 10'd16) && n < 1000) begin
         tick();
         n++;
      end
      check("s_wrap_found", 32'(n < 1000), 32'd1);
      tick();
      check("wrap_drawx", 32'(dx_s), 32'd0);
      check("wrap_drawy", 32'(dy_s), 32'd0);
      check("wrap_frame_start", 32'(fs_s), 32'd1);
      check("wrap_line_start", 32'(ls_s), 32'd1);
      check("wrap_blank", 32'(blank_s), 32'd1);
      check("wrap_hs", 32'(hs_s), 32'd1);
      check("wrap_vs", 32'(vs_s), 32'd1);

      // one-clock reset in mid-frame at (15,8)
      n = 0;
      while (!(dx_s == 10'd15 && dy_s == 10'd8) && n < 1000) begin
         tick();
         n++;
      end
      check("s_mid_found", 32'(n < 1000), 32'd1);
      rst_s_n = 1'b0;
      tick();
      check("mid_rst_drawx", 32'(dx_s), 32'd0);
      check("mid_rst_drawy", 32'(dy_s), 32'd0);
      check("mid_rst_blank", 32'(blank_s), 32'd0);
      check("mid_rst_hs", 32'(hs_s), 32'd1);
      check("mid_rst_vs", 32'(vs_s), 32'd1);
      check("mid_rst_ls", 32'(ls_s), 32'd0);
      check("mid_rst_fs", 32'(fs_s), 32'd0);
      rst_s_n = 1'b1;
      tick();
      check("mid_rel_drawx", 32'(dx_s), 32'd1);
      check("mid_rel_drawy", 32'(dy_s), 32'd0);
      check("mid_rel_blank", 32'(blank_s), 32'd1);
      check("mid_rel_fs", 32'(fs_s), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
